// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory request per access over a
// req/ready handshake, stalls the pipeline until it completes, and formats load data.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_alu_output,
    input  logic [31:0] mem_rs2_data,
    input  logic [2:0]  mem_funct3,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    output logic [31:0] mem_mem_output,
    output logic        lsu_stall,
    output logic        lsu_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic        acc, issue, misaligned, illegal;
    logic [1:0]  off;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign acc = mem_memread | mem_memwrite;
    assign off = mem_alu_output[1:0];

    assign misaligned = ((mem_funct3[1:0] == 2'b01) && off[0]) ||
                        ((mem_funct3[1:0] == 2'b10) && (off != 2'b00));
    assign illegal    = (mem_memread && mem_memwrite) ||
                        (mem_memread  && !(mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                        (mem_memwrite && !(mem_funct3 inside {3'b000, 3'b001, 3'b010}));
    assign lsu_fault  = acc && (misaligned || illegal);
    assign issue      = acc && !lsu_fault;

    // Store lane replication and byte enables.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        st_wdata = mem_rs2_data;
        st_wstrb = 4'b1111;
        case (mem_funct3[1:0])
            2'b00: begin
                st_wdata = {4{mem_rs2_data[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{mem_rs2_data[15:0]}};
                st_wstrb = off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load extraction; the EX/MEM fields are held steady by the stall while BUSY.
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (off)
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            2'b11:   ld_byte = dmem_rdata[31:24];
            default: ;
        endcase
        ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (mem_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = BUSY;
            BUSY:    if (dmem_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lsu_stall = 1'b0;
        case (state)
            IDLE:    lsu_stall = issue;
            BUSY:    lsu_stall = 1'b1;
            default: lsu_stall = 1'b0;
        endcase
    end

    // Request registers and the load result; dmem_we distinguishes loads at completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'h0;
            dmem_wdata     <= 32'h0;
            dmem_wstrb     <= 4'b0000;
            mem_mem_output <= 32'h0;
        end else if (state == IDLE && issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_memwrite;
            dmem_addr  <= {mem_alu_output[31:2], 2'b00};
            dmem_wdata <= st_wdata;
            dmem_wstrb <= mem_memwrite ? st_wstrb : 4'b0000;
        end else if (state == BUSY && dmem_ready) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
            if (!dmem_we) mem_mem_output <= ld_data;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, wait states, faults and reset mid-access.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_alu_output, mem_rs2_data, mem_mem_output;
    logic [2:0]  mem_funct3;
    logic        mem_memread, mem_memwrite;
    logic        lsu_stall, lsu_fault;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_alu_output (mem_alu_output),
        .mem_rs2_data   (mem_rs2_data),
        .mem_funct3     (mem_funct3),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_mem_output (mem_mem_output),
        .lsu_stall      (lsu_stall),
        .lsu_fault      (lsu_fault),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [2:0] f3);
        mem_memread    = rd;
        mem_memwrite   = wr;
        mem_alu_output = addr;
        mem_rs2_data   = rs2;
        mem_funct3     = f3;
        #1;
    endtask

    // One complete access: IDLE (issue), BUSY (+waits), DONE, back to IDLE.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_out, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb);
        drive(rd, wr, addr, rs2, f3);
        check({tag, ".idle_stall"}, lsu_stall, 1'b1);
        check({tag, ".idle_fault"}, lsu_fault, 1'b0);
        check({tag, ".idle_req"},   dmem_req,  1'b0);
        dmem_ready = 1'b0;
        tick();
        check({tag, ".req"},   dmem_req,   1'b1);
        check({tag, ".we"},    dmem_we,    wr);
        check({tag, ".addr"},  dmem_addr,  {addr[31:2], 2'b00});
        check({tag, ".wstrb"}, dmem_wstrb, exp_wstrb);
        if (wr) check({tag, ".wdata"}, dmem_wdata, exp_wdata);
        check({tag, ".busy_stall"}, lsu_stall, 1'b1);
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, ".wait_req"},   dmem_req,  1'b1);
            check({tag, ".wait_addr"},  dmem_addr, {addr[31:2], 2'b00});
            check({tag, ".wait_stall"}, lsu_stall, 1'b1);
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ready = 1'b0;
        check({tag, ".done_stall"}, lsu_stall,      1'b0);
        check({tag, ".done_req"},   dmem_req,       1'b0);
        check({tag, ".done_wstrb"}, dmem_wstrb,     4'b0000);
        check({tag, ".done_out"},   mem_mem_output, exp_out);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        check({tag, ".idle_again"}, lsu_stall, 1'b0);
    endtask

    task automatic fault_case(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] exp_out);
        dmem_ready = 1'b1;
        drive(rd, wr, addr, 32'h5555_5555, f3);
        check({tag, ".fault"}, lsu_fault, 1'b1);
        check({tag, ".stall"}, lsu_stall, 1'b0);
        tick();
        check({tag, ".req"}, dmem_req,       1'b0);
        check({tag, ".out"}, mem_mem_output, exp_out);
        tick();
        check({tag, ".req2"}, dmem_req, 1'b0);
        dmem_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        tick();
        check("rst.req",   dmem_req,       1'b0);
        check("rst.we",    dmem_we,        1'b0);
        check("rst.addr",  dmem_addr,      32'h0);
        check("rst.wdata", dmem_wdata,     32'h0);
        check("rst.wstrb", dmem_wstrb,     4'b0000);
        check("rst.out",   mem_mem_output, 32'h0);
        check("rst.stall", lsu_stall,      1'b0);
        check("rst.fault", lsu_fault,      1'b0);
        rst_n = 1'b1;
        tick();

        access("lw",  1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 4'b0000);
        access("lb",  1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 0, 32'h80FF1234, 32'hFFFFFF80, 32'h0, 4'b0000);
        access("lbu", 1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 0, 32'h80FF1234, 32'h00000080, 32'h0, 4'b0000);
        access("lh",  1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 0, 32'h80FF1234, 32'hFFFF80FF, 32'h0, 4'b0000);
        access("lhu", 1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 0, 32'h80FF1234, 32'h000080FF, 32'h0, 4'b0000);
        access("lb0", 1'b1, 1'b0, 32'h104, 32'h0, 3'b000, 1, 32'h80FF1234, 32'h00000034, 32'h0, 4'b0000);

        // Stores leave the load result alone, even with garbage on rdata.
        access("sb", 1'b0, 1'b1, 32'h201, 32'h000000AB, 3'b000, 0, 32'h11111111, 32'h00000034, 32'hABABABAB, 4'b0010);
        access("sh", 1'b0, 1'b1, 32'h202, 32'h00001234, 3'b001, 2, 32'h22222222, 32'h00000034, 32'h12341234, 4'b1100);
        access("sw", 1'b0, 1'b1, 32'h300, 32'hA5A5_0F0F, 3'b010, 0, 32'h33333333, 32'h00000034, 32'hA5A50F0F, 4'b1111);

        access("lw_wait", 1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 4, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 4'b0000);

        fault_case("f_lw_mis",  1'b1, 1'b0, 32'h102, 3'b010, 32'hCAFEF00D);
        fault_case("f_sh_mis",  1'b0, 1'b1, 32'h101, 3'b001, 32'hCAFEF00D);
        fault_case("f_rdwr",    1'b1, 1'b1, 32'h100, 3'b010, 32'hCAFEF00D);
        fault_case("f_ld_f3",   1'b1, 1'b0, 32'h100, 3'b011, 32'hCAFEF00D);
        fault_case("f_st_f3",   1'b0, 1'b1, 32'h100, 3'b100, 32'hCAFEF00D);

        // Reset while BUSY abandons the request.
        drive(1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
        tick();
        check("rb.busy_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        check("rb.req",   dmem_req,       1'b0);
        check("rb.out",   mem_mem_output, 32'h0);
        check("rb.stall", lsu_stall,      1'b0);
        rst_n = 1'b1;
        tick();
        access("lw_post", 1'b1, 1'b0, 32'h40C, 32'h0, 3'b010, 0, 32'h0BADF00D, 32'h0BADF00D, 32'h0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
